mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: instruction fetch and load/store share
// a single memory port. One transaction is in flight at a time. Data has
// priority, bounded by a starvation counter that forces a fetch grant after
// STARVE_MAX consecutive data grants. A wait counter aborts transactions
// that never see mem_ready.
module mem_port_arbiter #(
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int              SCW        = $clog2(STARVE_MAX + 1);
  localparam int              WCW        = $clog2(TIMEOUT + 1);
  localparam logic [SCW-1:0]  STARVE_LIM = SCW'(STARVE_MAX);
  localparam logic [WCW-1:0]  WAIT_LAST  = WCW'(TIMEOUT - 1);
  localparam logic [2:0]      SIZE_WORD  = 3'b010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [SCW-1:0] starve_q, starve_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           if_ack_q, if_ack_d;
  logic           d_ack_q, d_ack_d;
  logic           err_q, err_d;
  logic [31:0]    if_rdata_q, if_rdata_d;
  logic [31:0]    d_rdata_q, d_rdata_d;
  logic           mem_we_q, mem_we_d;
  logic [2:0]     mem_size_q, mem_size_d;
  logic [31:0]    mem_addr_q, mem_addr_d;
  logic [31:0]    mem_wdata_q, mem_wdata_d;

  // Arbitration, request capture, completion and timeout handling.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_we_d    = mem_we_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        // No grant in an ack cycle: the acked requester still shows its old
        // request, and holding off the other side keeps the grant order fair.
        if (!(if_ack_q || d_ack_q)) begin
          if (d_req && (!if_req || (starve_q < STARVE_LIM))) begin
            state_d     = D_BUSY;
            wait_d      = '0;
            mem_we_d    = d_we;
            mem_size_d  = d_size;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            // A pending fetch implies starve_q < STARVE_LIM here, so this saturates.
            if (if_req) starve_d = starve_q + 1'b1;
          end else if (if_req) begin
            state_d     = IF_BUSY;
            wait_d      = '0;
            starve_d    = '0;
            mem_we_d    = 1'b0;
            mem_size_d  = SIZE_WORD;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end
        end
      end
      IF_BUSY, D_BUSY: begin
        // mem_ready wins over a simultaneous timeout.
        if (mem_ready || (wait_q == WAIT_LAST)) begin
          state_d = IDLE;
          err_d   = !mem_ready;
          if (state_q == IF_BUSY) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ready ? mem_rdata : 32'd0;
          end else begin
            d_ack_d = 1'b1;
            if (!mem_ready)    d_rdata_d = 32'd0;
            else if (!mem_we_q) d_rdata_d = mem_rdata;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything including data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      wait_q      <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = mem_we_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;

endmodule
